btle_rx_pdu_packer: RTL and testbench

BTLE_RX_PDU_PACKER -- requirements
Module: btle_rx_pdu_packer

---
 rtl/btle_rx_pdu_packer_if.sv | 29 ++
 rtl/btle_rx_pdu_packer.sv | 175 +++++++++++++++++
 tb/tb_btle_rx_pdu_packer.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/btle_rx_pdu_packer_if.sv
// Bus bundle for the BTLE receive PDU packer: bit stream in, octet buffer
// read port and decode status out.
interface btle_rx_pdu_packer_if;
  logic        rx_hit_flag;
  logic        bit_in;
  logic        bit_valid;
  logic [5:0]  rx_channel_number;
  logic [23:0] rx_crc_state_init_bit;
  logic [5:0]  rx_pdu_octet_mem_addr;
  logic [7:0]  rx_pdu_octet_mem_data;
  logic        rx_decode_run;
  logic        rx_decode_end;
  logic        rx_crc_ok;
  logic [6:0]  rx_payload_length;

  modport master (
    output rx_hit_flag, bit_in, bit_valid, rx_channel_number,
           rx_crc_state_init_bit, rx_pdu_octet_mem_addr,
    input  rx_pdu_octet_mem_data, rx_decode_run, rx_decode_end,
           rx_crc_ok, rx_payload_length
  );

  modport slave (
    input  rx_hit_flag, bit_in, bit_valid, rx_channel_number,
           rx_crc_state_init_bit, rx_pdu_octet_mem_addr,
    output rx_pdu_octet_mem_data, rx_decode_run, rx_decode_end,
           rx_crc_ok, rx_payload_length
  );
endinterface

// File: rtl/btle_rx_pdu_packer.sv
// Packs a received BTLE PDU bit stream into a 64x8 octet buffer and checks its CRC.
// Optional dewhitening of the incoming bits is enabled with BTLE_RX_DEWHITEN_EN.
module btle_rx_pdu_packer (
  input logic                   clk,
  input logic                   rst,
  btle_rx_pdu_packer_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, CRC} state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic [9:0]  r_bitCnt;
  logic [7:0]  r_octetCnt;
  logic [7:0]  r_shift;
  logic [23:0] r_lfsr;
  logic        r_wrEn;
  logic [5:0]  r_wrAddr;
  logic [7:0]  r_wrData;
  logic        r_lenWr;
  logic [6:0]  r_len;
  logic        r_run;
  logic        r_end;
  logic        r_crcOk;
  logic [7:0]  r_rdData;
  logic [7:0]  r_mem [0:63];

  logic        w_bit;
  logic        w_fb;
  logic        w_advance;
  logic        w_crcDone;
  logic [7:0]  w_octet;
  logic [23:0] w_lfsrNext;

`ifdef BTLE_RX_DEWHITEN_EN
  // Whitening LFSR runs in lockstep with every bit consumed after the hit
  logic [6:0] r_white;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_white <= '0;
    end else if (bus.rx_hit_flag) begin
      r_white <= {1'b1, bus.rx_channel_number[0], bus.rx_channel_number[1],
                  bus.rx_channel_number[2], bus.rx_channel_number[3],
                  bus.rx_channel_number[4], bus.rx_channel_number[5]};
    end else if (w_advance) begin
      r_white <= {r_white[0], r_white[6:5], r_white[4] ^ r_white[0], r_white[3:1]};
    end
  end

  assign w_bit = bus.bit_in ^ r_white[0];
`else
  assign w_bit = bus.bit_in;
`endif

  // A hit always wins, so a bit arriving with it never advances the PDU
  assign w_advance  = bus.bit_valid && !bus.rx_hit_flag && (r_state != IDLE);
  assign w_octet    = {w_bit, r_shift[7:1]};
  assign w_fb       = r_lfsr[23] ^ w_bit;
  assign w_lfsrNext = {r_lfsr[22:0], 1'b0} ^ (w_fb ? 24'h00065B : 24'h000000);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // The length octet is still in the shifter on the 16th bit, so peek at it there
  always_comb begin
    w_nextState = r_state;
    w_crcDone   = 1'b0;
    if (bus.rx_hit_flag) begin
      w_nextState = HEADER;
    end else if (w_advance) begin
      case (r_state)
        HEADER: begin
          if (r_bitCnt == 10'd15) begin
            w_nextState = (w_octet[6:0] == 7'd0) ? CRC : PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (r_bitCnt == ({r_len, 3'b000} - 10'd1)) begin
            w_nextState = CRC;
          end
        end
        CRC: begin
          if (r_bitCnt == 10'd23) begin
            w_nextState = IDLE;
            w_crcDone   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bitCnt   <= '0;
      r_octetCnt <= '0;
      r_shift    <= '0;
      r_lfsr     <= '0;
      r_wrEn     <= 1'b0;
      r_wrAddr   <= '0;
      r_wrData   <= '0;
      r_lenWr    <= 1'b0;
      r_len      <= '0;
      r_run      <= 1'b0;
      r_end      <= 1'b0;
      r_crcOk    <= 1'b0;
    end else if (bus.rx_hit_flag) begin
      r_bitCnt   <= '0;
      r_octetCnt <= '0;
      r_shift    <= '0;
      r_lfsr     <= bus.rx_crc_state_init_bit;
      r_wrEn     <= 1'b0;
      r_lenWr    <= 1'b0;
      r_run      <= 1'b1;
      r_end      <= 1'b0;
      r_crcOk    <= 1'b0;
    end else begin
      r_wrEn  <= 1'b0;
      r_lenWr <= 1'b0;
      r_end   <= 1'b0;
      if (r_end) begin
        r_run <= 1'b0;
      end
      if (r_lenWr) begin
        r_len <= r_wrData[6:0];
      end
      if (w_advance) begin
        r_lfsr   <= w_lfsrNext;
        r_bitCnt <= (w_nextState != r_state) ? 10'd0 : r_bitCnt + 10'd1;
        // Octets past the buffer end are still counted but never stored
        if (r_state != CRC) begin
          r_shift <= w_octet;
          if (r_bitCnt[2:0] == 3'd7) begin
            r_wrEn     <= (r_octetCnt[7:6] == 2'b00);
            r_wrAddr   <= r_octetCnt[5:0];
            r_wrData   <= w_octet;
            r_lenWr    <= (r_octetCnt == 8'd1);
            r_octetCnt <= r_octetCnt + 8'd1;
          end
        end
        if (w_crcDone) begin
          r_end   <= 1'b1;
          r_crcOk <= (w_lfsrNext == 24'd0);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (r_wrEn) begin
      r_mem[r_wrAddr] <= r_wrData;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdData <= '0;
    end else begin
      r_rdData <= r_mem[bus.rx_pdu_octet_mem_addr];
    end
  end

  assign bus.rx_pdu_octet_mem_data = r_rdData;
  assign bus.rx_decode_run         = r_run;
  assign bus.rx_decode_end         = r_end;
  assign bus.rx_crc_ok             = r_crcOk;
  assign bus.rx_payload_length     = r_len;

endmodule

// File: tb/tb_btle_rx_pdu_packer.sv
// Directed self-checking bench for btle_rx_pdu_packer; whitens its stimulus
// when BTLE_RX_DEWHITEN_EN is defined so every scenario runs in both builds.
module tb_btle_rx_pdu_packer;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  btle_rx_pdu_packer_if bus ();

  btle_rx_pdu_packer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int          errors   = 0;
  int          checks   = 0;
  int          endCount = 0;
  int          gapEvery = 0;
  int          bitNum   = 0;
  logic [23:0] tbCrc;
  logic [6:0]  tbWhite;
  logic [5:0]  tbChannel = 6'd0;
  logic [7:0]  payload [0:127];

  // Counts every cycle in which the end pulse is high
  always @(posedge clk) begin
    if (bus.rx_decode_end === 1'b1) endCount++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] crcStep(input logic [23:0] s, input logic d);
    logic fb;
    fb = s[23] ^ d;
    return {s[22:0], 1'b0} ^ (fb ? 24'h00065B : 24'h000000);
  endfunction

  task automatic hitPulse(input logic [23:0] seed, input logic strayBit);
    bus.rx_hit_flag           = 1'b1;
    bus.rx_crc_state_init_bit = seed;
    bus.rx_channel_number     = tbChannel;
    bus.bit_valid             = strayBit;
    bus.bit_in                = strayBit;
    tick();
    bus.rx_hit_flag = 1'b0;
    bus.bit_valid   = 1'b0;
    tbCrc   = seed;
    tbWhite = {1'b1, tbChannel[0], tbChannel[1], tbChannel[2],
               tbChannel[3], tbChannel[4], tbChannel[5]};
    bitNum  = 0;
  endtask

  task automatic sendBit(input logic d, input logic flip);
    logic air;
    if (gapEvery > 0 && (bitNum % gapEvery) == gapEvery - 1) tick();
    air = d ^ flip;
`ifdef BTLE_RX_DEWHITEN_EN
    air = air ^ tbWhite[0];
`endif
    tbWhite = {tbWhite[0], tbWhite[6:5], tbWhite[4] ^ tbWhite[0], tbWhite[3:1]};
    tbCrc   = crcStep(tbCrc, d);
    bus.bit_in    = air;
    bus.bit_valid = 1'b1;
    tick();
    bus.bit_valid = 1'b0;
    bitNum++;
  endtask

  task automatic sendOctet(input logic [7:0] v, input logic [7:0] flipMask);
    for (int i = 0; i < 8; i++) sendBit(v[i], flipMask[i]);
  endtask

  // Sends everything up to but not including the final CRC bit
  task automatic sendPduBody(input logic [7:0] hdr0, input logic [7:0] lenOct,
                             input int nPay, input int flipOctet,
                             input logic [23:0] seed, input logic strayBit);
    hitPulse(seed, strayBit);
    sendOctet(hdr0, 8'h00);
    sendOctet(lenOct, 8'h00);
    for (int i = 0; i < nPay; i++)
      sendOctet(payload[i], (flipOctet == i + 2) ? 8'h04 : 8'h00);
    for (int i = 0; i < 23; i++) sendBit(tbCrc[23], 1'b0);
  endtask

  task automatic finishPdu();
    sendBit(tbCrc[23], 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.rx_hit_flag = 1'b1;
    tick();
    bus.rx_hit_flag = 1'b0;
    checks++; if (bus.rx_decode_run !== 1'b0) begin errors++; $display("[TB] FAIL reset_run: got %b expected 0", bus.rx_decode_run); end
    checks++; if (bus.rx_decode_end !== 1'b0) begin errors++; $display("[TB] FAIL reset_end: got %b expected 0", bus.rx_decode_end); end
    checks++; if (bus.rx_crc_ok !== 1'b0) begin errors++; $display("[TB] FAIL reset_crc: got %b expected 0", bus.rx_crc_ok); end
    checks++; if (bus.rx_payload_length !== 7'd0) begin errors++; $display("[TB] FAIL reset_len: got %0d expected 0", bus.rx_payload_length); end
    checks++; if (bus.rx_pdu_octet_mem_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_data: got %h expected 00", bus.rx_pdu_octet_mem_data); end
    tick();
    rst = 1'b0;
    tick();
    checks++; if (bus.rx_decode_run !== 1'b0) begin errors++; $display("[TB] FAIL reset_priority_run: got %b expected 0", bus.rx_decode_run); end
  endtask

  task automatic test_basic();
    logic [7:0] expData [0:4];
    expData = '{8'h00, 8'h03, 8'h11, 8'h22, 8'h33};
    payload[0] = 8'h11; payload[1] = 8'h22; payload[2] = 8'h33;
    gapEvery = 3;
    endCount = 0;
    sendPduBody(8'h00, 8'h03, 3, -1, 24'h555555, 1'b0);
    checks++; if (bus.rx_decode_end !== 1'b0) begin errors++; $display("[TB] FAIL basic_early_end: got %b expected 0", bus.rx_decode_end); end
    finishPdu();
    gapEvery = 0;
    checks++; if (bus.rx_decode_end !== 1'b1) begin errors++; $display("[TB] FAIL basic_end: got %b expected 1", bus.rx_decode_end); end
    checks++; if (bus.rx_decode_run !== 1'b1) begin errors++; $display("[TB] FAIL basic_run: got %b expected 1", bus.rx_decode_run); end
    checks++; if (bus.rx_crc_ok !== 1'b1) begin errors++; $display("[TB] FAIL basic_crc: got %b expected 1", bus.rx_crc_ok); end
    checks++; if (bus.rx_payload_length !== 7'd3) begin errors++; $display("[TB] FAIL basic_len: got %0d expected 3", bus.rx_payload_length); end
    tick();
    checks++; if (bus.rx_decode_end !== 1'b0) begin errors++; $display("[TB] FAIL basic_end_pulse: got %b expected 0", bus.rx_decode_end); end
    checks++; if (bus.rx_decode_run !== 1'b0) begin errors++; $display("[TB] FAIL basic_run_drop: got %b expected 0", bus.rx_decode_run); end
    checks++; if (bus.rx_crc_ok !== 1'b1) begin errors++; $display("[TB] FAIL basic_crc_hold: got %b expected 1", bus.rx_crc_ok); end
    checks++; if (endCount !== 1) begin errors++; $display("[TB] FAIL basic_end_count: got %0d expected 1", endCount); end
    for (int a = 0; a < 5; a++) begin
      bus.rx_pdu_octet_mem_addr = 6'(a);
      tick();
      checks++; if (bus.rx_pdu_octet_mem_data !== expData[a]) begin errors++; $display("[TB] FAIL basic_mem[%0d]: got %h expected %h", a, bus.rx_pdu_octet_mem_data, expData[a]); end
    end
  endtask

  task automatic test_bad_crc();
    payload[0] = 8'h11; payload[1] = 8'h22; payload[2] = 8'h33;
    endCount = 0;
    sendPduBody(8'h00, 8'h03, 3, 3, 24'h555555, 1'b0);
    finishPdu();
    checks++; if (bus.rx_decode_end !== 1'b1) begin errors++; $display("[TB] FAIL badcrc_end: got %b expected 1", bus.rx_decode_end); end
    checks++; if (bus.rx_crc_ok !== 1'b0) begin errors++; $display("[TB] FAIL badcrc_crc: got %b expected 0", bus.rx_crc_ok); end
    tick();
    checks++; if (endCount !== 1) begin errors++; $display("[TB] FAIL badcrc_end_count: got %0d expected 1", endCount); end
  endtask

  task automatic test_len0();
    sendPduBody(8'h0A, 8'h00, 0, -1, 24'h123456, 1'b0);
    checks++; if (bus.rx_decode_end !== 1'b0) begin errors++; $display("[TB] FAIL len0_early_end: got %b expected 0", bus.rx_decode_end); end
    finishPdu();
    checks++; if (bus.rx_decode_end !== 1'b1) begin errors++; $display("[TB] FAIL len0_end: got %b expected 1", bus.rx_decode_end); end
    checks++; if (bus.rx_crc_ok !== 1'b1) begin errors++; $display("[TB] FAIL len0_crc: got %b expected 1", bus.rx_crc_ok); end
    checks++; if (bus.rx_payload_length !== 7'd0) begin errors++; $display("[TB] FAIL len0_len: got %0d expected 0", bus.rx_payload_length); end
    bus.rx_pdu_octet_mem_addr = 6'd0;
    tick();
    checks++; if (bus.rx_pdu_octet_mem_data !== 8'h0A) begin errors++; $display("[TB] FAIL len0_mem0: got %h expected 0a", bus.rx_pdu_octet_mem_data); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] expData [0:3];
    expData = '{8'h02, 8'h02, 8'hAB, 8'hCD};
    endCount = 0;
    hitPulse(24'h555555, 1'b0);
    sendOctet(8'h00, 8'h00);
    sendOctet(8'h03, 8'h00);
    sendOctet(8'h11, 8'h00);
    sendBit(1'b0, 1'b0);
    sendBit(1'b1, 1'b0);
    payload[0] = 8'hAB; payload[1] = 8'hCD;
    sendPduBody(8'h02, 8'h02, 2, -1, 24'hABCDEF, 1'b1);
    checks++; if (endCount !== 0) begin errors++; $display("[TB] FAIL b2b_aborted_end: got %0d expected 0", endCount); end
    finishPdu();
    checks++; if (bus.rx_decode_end !== 1'b1) begin errors++; $display("[TB] FAIL b2b_end: got %b expected 1", bus.rx_decode_end); end
    checks++; if (bus.rx_crc_ok !== 1'b1) begin errors++; $display("[TB] FAIL b2b_crc: got %b expected 1", bus.rx_crc_ok); end
    checks++; if (bus.rx_payload_length !== 7'd2) begin errors++; $display("[TB] FAIL b2b_len: got %0d expected 2", bus.rx_payload_length); end
    tick();
    checks++; if (endCount !== 1) begin errors++; $display("[TB] FAIL b2b_end_count: got %0d expected 1", endCount); end
    for (int a = 0; a < 4; a++) begin
      bus.rx_pdu_octet_mem_addr = 6'(a);
      tick();
      checks++; if (bus.rx_pdu_octet_mem_data !== expData[a]) begin errors++; $display("[TB] FAIL b2b_mem[%0d]: got %h expected %h", a, bus.rx_pdu_octet_mem_data, expData[a]); end
    end
  endtask

  task automatic test_reset_mid();
    endCount = 0;
    hitPulse(24'h555555, 1'b0);
    sendOctet(8'h00, 8'h00);
    sendOctet(8'h03, 8'h00);
    sendOctet(8'h11, 8'h00);
    sendBit(1'b1, 1'b0);
    sendBit(1'b0, 1'b0);
    rst = 1'b1;
    tick();
    checks++; if (bus.rx_decode_run !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_run: got %b expected 0", bus.rx_decode_run); end
    checks++; if (bus.rx_decode_end !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_end: got %b expected 0", bus.rx_decode_end); end
    checks++; if (bus.rx_crc_ok !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_crc: got %b expected 0", bus.rx_crc_ok); end
    checks++; if (bus.rx_payload_length !== 7'd0) begin errors++; $display("[TB] FAIL rstmid_len: got %0d expected 0", bus.rx_payload_length); end
    checks++; if (bus.rx_pdu_octet_mem_data !== 8'h00) begin errors++; $display("[TB] FAIL rstmid_data: got %h expected 00", bus.rx_pdu_octet_mem_data); end
    rst = 1'b0;
    bus.bit_valid = 1'b1;
    bus.bit_in    = 1'b1;
    repeat (30) tick();
    bus.bit_valid = 1'b0;
    checks++; if (endCount !== 0) begin errors++; $display("[TB] FAIL rstmid_no_end: got %0d expected 0", endCount); end
    checks++; if (bus.rx_decode_run !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_idle_run: got %b expected 0", bus.rx_decode_run); end
    payload[0] = 8'h11; payload[1] = 8'h22; payload[2] = 8'h33;
    sendPduBody(8'h00, 8'h03, 3, -1, 24'h555555, 1'b0);
    finishPdu();
    checks++; if (bus.rx_decode_end !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_next_end: got %b expected 1", bus.rx_decode_end); end
    checks++; if (bus.rx_crc_ok !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_next_crc: got %b expected 1", bus.rx_crc_ok); end
    bus.rx_pdu_octet_mem_addr = 6'd2;
    tick();
    checks++; if (bus.rx_pdu_octet_mem_data !== 8'h11) begin errors++; $display("[TB] FAIL rstmid_next_mem2: got %h expected 11", bus.rx_pdu_octet_mem_data); end
  endtask

  task automatic test_long_pdu();
    for (int i = 0; i < 128; i++) payload[i] = 8'(i * 5 + 3);
    payload[62] = 8'hEE;
    sendPduBody(8'h05, 8'hC6, 70, -1, 24'h0F0F0F, 1'b0);
    finishPdu();
    checks++; if (bus.rx_crc_ok !== 1'b1) begin errors++; $display("[TB] FAIL long_crc: got %b expected 1", bus.rx_crc_ok); end
    checks++; if (bus.rx_payload_length !== 7'd70) begin errors++; $display("[TB] FAIL long_len: got %0d expected 70", bus.rx_payload_length); end
    bus.rx_pdu_octet_mem_addr = 6'd0;
    tick();
    checks++; if (bus.rx_pdu_octet_mem_data !== 8'h05) begin errors++; $display("[TB] FAIL long_mem0: got %h expected 05", bus.rx_pdu_octet_mem_data); end
    bus.rx_pdu_octet_mem_addr = 6'd1;
    tick();
    checks++; if (bus.rx_pdu_octet_mem_data !== 8'hC6) begin errors++; $display("[TB] FAIL long_mem1: got %h expected c6", bus.rx_pdu_octet_mem_data); end
    bus.rx_pdu_octet_mem_addr = 6'd63;
    tick();
    checks++; if (bus.rx_pdu_octet_mem_data !== 8'h34) begin errors++; $display("[TB] FAIL long_mem63: got %h expected 34", bus.rx_pdu_octet_mem_data); end
  endtask

  task automatic test_dewhiten();
    logic [7:0] expData [0:4];
    expData = '{8'h00, 8'h03, 8'h11, 8'h22, 8'h33};
    tbChannel = 6'd37;
    payload[0] = 8'h11; payload[1] = 8'h22; payload[2] = 8'h33;
    sendPduBody(8'h00, 8'h03, 3, -1, 24'h555555, 1'b0);
    finishPdu();
    checks++; if (bus.rx_crc_ok !== 1'b1) begin errors++; $display("[TB] FAIL dewhiten_crc: got %b expected 1", bus.rx_crc_ok); end
    for (int a = 0; a < 5; a++) begin
      bus.rx_pdu_octet_mem_addr = 6'(a);
      tick();
      checks++; if (bus.rx_pdu_octet_mem_data !== expData[a]) begin errors++; $display("[TB] FAIL dewhiten_mem[%0d]: got %h expected %h", a, bus.rx_pdu_octet_mem_data, expData[a]); end
    end
    tbChannel = 6'd0;
  endtask

  initial begin
    rst                       = 1'b1;
    bus.rx_hit_flag           = 1'b0;
    bus.bit_in                = 1'b0;
    bus.bit_valid             = 1'b0;
    bus.rx_channel_number     = 6'd0;
    bus.rx_crc_state_init_bit = 24'd0;
    bus.rx_pdu_octet_mem_addr = 6'd0;
    $display("[TB] starting btle_rx_pdu_packer tests");
    test_reset();
    test_basic();
    test_bad_crc();
    test_len0();
    test_back_to_back();
    test_reset_mid();
    test_long_pdu();
`ifdef BTLE_RX_DEWHITEN_EN
    test_dewhiten();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
